// File: rtl/bcd_pkg.sv
// ============================================================================
// Module  : bcd_pkg
// Brief   : Shared state type and digit constants for the BCD writer slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } wr_state_t;

  localparam logic [3:0] DIGIT_POS_EXT = 4'd0;
  localparam logic [3:0] DIGIT_NEG_EXT = 4'd9;
  localparam logic [3:0] DIGIT_MAX     = 4'd9;
  // Digits at or above this value are negative in ten's complement.
  localparam logic [3:0] DIGIT_SPLIT   = 4'd5;

endpackage

`default_nettype wire

// File: rtl/bcd_sext_writer_if.sv
// ============================================================================
// Module  : bcd_sext_writer_if
// Brief   : Digit input handshake plus RAM write bus of the BCD writer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_sext_writer_if;
  logic        in_valid;
  logic [3:0]  in_digit;
  logic        in_ready;
  logic [15:0] addr;
  logic [7:0]  data;
  logic        we_;
  logic        wrap;
  logic        err;
  logic [15:0] count;

  modport master (
    output in_valid, in_digit,
    input  in_ready, addr, data, we_, wrap, err, count
  );

  modport slave (
    input  in_valid, in_digit,
    output in_ready, addr, data, we_, wrap, err, count
  );
endinterface

`default_nettype wire

// File: rtl/bcd_sign_extend.sv
// ============================================================================
// Module  : bcd_sign_extend
// Brief   : Sign-extends a one-digit ten's-complement BCD value to two digits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_sign_extend
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] packed_byte,
  output logic       valid
);

  always_comb begin
    valid       = (digit <= DIGIT_MAX);
    packed_byte = 8'h00;
    if (valid) begin
      packed_byte = {(digit < DIGIT_SPLIT) ? DIGIT_POS_EXT : DIGIT_NEG_EXT, digit};
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_sext_writer.sv
// ============================================================================
// Module  : bcd_sext_writer
// Brief   : Accepts BCD digits, sign-extends them and writes consecutive RAM
//           bytes with a SETUP / STROBE / HOLD bus cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_sext_writer
  import bcd_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] END_ADDR  = 16'h001F,
  parameter int          WE_CYCLES = 2
) (
  input  logic               clock,
  input  logic               reset,
  bcd_sext_writer_if.slave   bus
);

  localparam int                 c_CNT_W    = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WE_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  wr_state_t          r_state;
  wr_state_t          w_next;
  logic               r_armed;
  logic [c_CNT_W-1:0] r_strobe_cnt;
  logic [15:0]        r_addr;
  logic [15:0]        r_count;
  logic [7:0]         r_data;
  logic               r_wrap;
  logic               r_err;
  logic [7:0]         w_byte;
  logic               w_digit_ok;
  logic               w_ready;
  logic               w_accept;
  logic               w_strobe_done;

  bcd_sign_extend u_sext (
    .digit       (bus.in_digit),
    .packed_byte (w_byte),
    .valid       (w_digit_ok)
  );

  // r_armed keeps in_ready low until the first edge after reset release.
  assign w_ready       = r_armed && (r_state == IDLE);
  assign w_accept      = bus.in_valid && w_ready;
  assign w_strobe_done = (r_strobe_cnt == c_CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && w_digit_ok) w_next = SETUP;
      SETUP:   w_next = STROBE;
      STROBE:  if (w_strobe_done) w_next = HOLD;
      HOLD:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_armed      <= 1'b0;
      r_strobe_cnt <= '0;
      r_addr       <= BASE_ADDR;
      r_data       <= 8'h00;
      r_count      <= 16'h0000;
      r_wrap       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
      if (w_accept) begin
        if (w_digit_ok) r_data <= w_byte;
        else            r_err  <= 1'b1;
      end
      if (r_state == STROBE) r_strobe_cnt <= r_strobe_cnt + c_CNT_ONE;
      else                   r_strobe_cnt <= '0;
      // Address and count move only once the strobe has fully completed.
      if (r_state == HOLD) begin
        if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
        if (r_addr == END_ADDR) begin
          r_addr <= BASE_ADDR;
          r_wrap <= 1'b1;
        end else begin
          r_addr <= r_addr + 16'd1;
        end
      end
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.addr     = r_addr;
  assign bus.data     = r_data;
  assign bus.we_      = (r_state != STROBE);
  assign bus.wrap     = r_wrap;
  assign bus.err      = r_err;
  assign bus.count    = r_count;

endmodule

`default_nettype wire

// File: tb/tb_bcd_sext_writer.sv
// ============================================================================
// Module  : tb_bcd_sext_writer
// Brief   : Directed self-checking bench for two bcd_sext_writer instances.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_sext_writer;

  logic clk;
  logic rst;
  logic sel;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   last_acc;
  logic [15:0] ea   [2];
  logic [15:0] ecnt [2];

  bcd_sext_writer_if bus0 ();
  bcd_sext_writer_if bus1 ();

  bcd_sext_writer u_dut0 (.clock(clk), .reset(rst), .bus(bus0));
  bcd_sext_writer #(.BASE_ADDR(16'h0000), .END_ADDR(16'h001F), .WE_CYCLES(1))
    u_dut1 (.clock(clk), .reset(rst), .bus(bus1));

  logic        w_ready, w_we, w_wrap, w_err;
  logic [15:0] w_addr, w_count;
  logic [7:0]  w_data;
  assign w_ready = sel ? bus1.in_ready : bus0.in_ready;
  assign w_we    = sel ? bus1.we_      : bus0.we_;
  assign w_wrap  = sel ? bus1.wrap     : bus0.wrap;
  assign w_err   = sel ? bus1.err      : bus0.err;
  assign w_addr  = sel ? bus1.addr     : bus0.addr;
  assign w_count = sel ? bus1.count    : bus0.count;
  assign w_data  = sel ? bus1.data     : bus0.data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (obs !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [3:0] d);
    bus0.in_valid = v && !sel;
    bus0.in_digit = d;
    bus1.in_valid = v && sel;
    bus1.in_digit = d;
  endtask

  function automatic logic [7:0] sext(input logic [3:0] d);
    return (d < 4'd5) ? {4'h0, d} : {4'h9, d};
  endfunction

  // Called just after a falling edge; returns just after the falling edge
  // that follows the HOLD exit, so a held in_valid is accepted next edge.
  task automatic do_write(input logic [3:0] d, input logic [7:0] xd, input bit keep,
                          input bit xwrap, input bit chk_sp);
    int n;
    int low;
    int wc;
    int acc;
    wc = sel ? 1 : 2;
    set_in(1'b1, d);
    n = 0;
    while (!w_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", 32'(n < 20), 32'd1);
    if (n >= 20) begin
      set_in(1'b0, 4'd0);
      return;
    end
    acc = cyc + 1;
    if (chk_sp) check("spacing", 32'(acc - last_acc), 32'(wc + 3));
    last_acc = acc;
    @(negedge clk);
    if (!keep) set_in(1'b0, 4'd0);
    check("data", 32'(w_data), 32'(xd));
    check("addr", 32'(w_addr), 32'(ea[sel]));
    check("we_setup", 32'(w_we), 32'd1);
    check("ready_busy", 32'(w_ready), 32'd0);
    low = 0;
    for (int i = 0; i < wc + 1; i++) begin
      @(negedge clk);
      if (!w_we) begin
        low++;
        check("data_stable", 32'(w_data), 32'(xd));
        check("addr_stable", 32'(w_addr), 32'(ea[sel]));
      end
    end
    check("we_low_cycles", 32'(low), 32'(wc));
    @(negedge clk);
    ea[sel]   = (ea[sel] == 16'h001F) ? 16'h0000 : ea[sel] + 16'd1;
    ecnt[sel] = ecnt[sel] + 16'd1;
    check("addr_next", 32'(w_addr), 32'(ea[sel]));
    check("count", 32'(w_count), 32'(ecnt[sel]));
    check("wrap", 32'(w_wrap), 32'(xwrap));
  endtask

  task automatic reset_model();
    ea[0] = 16'h0000; ea[1] = 16'h0000;
    ecnt[0] = 16'h0000; ecnt[1] = 16'h0000;
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;
    last_acc = 0;
    sel      = 1'b0;
    rst      = 1'b1;
    reset_model();
    set_in(1'b0, 4'd0);

    #12;
    check("rst_addr",  32'(w_addr),  32'h0000);
    check("rst_data",  32'(w_data),  32'h00);
    check("rst_we",    32'(w_we),    32'd1);
    check("rst_ready", 32'(w_ready), 32'd0);
    check("rst_wrap",  32'(w_wrap),  32'd0);
    check("rst_err",   32'(w_err),   32'd0);
    check("rst_count", 32'(w_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_after_release", 32'(w_ready), 32'd0);
    @(negedge clk);
    check("ready_first_edge", 32'(w_ready), 32'd1);

    do_write(4'd3, 8'h03, 1'b0, 1'b0, 1'b0);
    do_write(4'd7, 8'h97, 1'b0, 1'b0, 1'b0);
    do_write(4'd5, 8'h95, 1'b0, 1'b0, 1'b0);
    do_write(4'd4, 8'h04, 1'b0, 1'b0, 1'b0);
    do_write(4'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Invalid digit: err pulse only, nothing written.
    set_in(1'b1, 4'hC);
    n = 0;
    while (!w_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("err_accept_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    set_in(1'b0, 4'd0);
    check("err_pulse",  32'(w_err),   32'd1);
    check("err_we",     32'(w_we),    32'd1);
    check("err_addr",   32'(w_addr),  32'(ea[0]));
    check("err_count",  32'(w_count), 32'(ecnt[0]));
    @(negedge clk);
    check("err_clear",  32'(w_err),   32'd0);
    check("err_we2",    32'(w_we),    32'd1);
    check("err_ready",  32'(w_ready), 32'd1);
    do_write(4'd2, 8'h02, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the strobe.
    set_in(1'b1, 4'd9);
    n = 0;
    while (!w_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    set_in(1'b0, 4'd0);
    @(negedge clk);
    check("midrst_we_low", 32'(w_we), 32'd0);
    #2 rst = 1'b1;
    #1;
    check("midrst_we",    32'(w_we),    32'd1);
    check("midrst_addr",  32'(w_addr),  32'h0000);
    check("midrst_count", 32'(w_count), 32'd0);
    check("midrst_ready", 32'(w_ready), 32'd0);
    check("midrst_data",  32'(w_data),  32'h00);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_ready_rel", 32'(w_ready), 32'd0);
    @(negedge clk);
    check("midrst_ready_edge", 32'(w_ready), 32'd1);

    // 33 back-to-back writes: full window, wrap, then back to base.
    for (int i = 0; i < 33; i++) begin
      logic [3:0] d;
      d = 4'(i % 10);
      do_write(d, sext(d), i < 32, i == 31, i > 0);
    end

    // Single-cycle strobe instance.
    sel = 1'b1;
    do_write(4'd3, 8'h03, 1'b1, 1'b0, 1'b0);
    do_write(4'd7, 8'h97, 1'b1, 1'b0, 1'b1);
    do_write(4'd5, 8'h95, 1'b1, 1'b0, 1'b1);
    do_write(4'd4, 8'h04, 1'b1, 1'b0, 1'b1);
    do_write(4'd0, 8'h00, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_sext_writer.md
Name: bcd_sext_writer

Overview:
- Writer-side counterpart of the BCD reader/classifier: accepts one-digit ten's-complement BCD values and sign-extends each to a two-digit packed byte {a1,a0}.
- Writes the bytes into consecutive addresses of an external 64Kx8 RAM using a multi-clock bus write cycle.
- Produces exactly the "reducible" two-digit encodings the reader side classifies: a1 is 0 for a digit in 0..4 and 9 for a digit in 5..9.

Parameters:
- BASE_ADDR, 16'h0000, first RAM address written after reset and after wrap.
- END_ADDR, 16'h001F, last address of the write window; the next write after it goes to BASE_ADDR.
- WE_CYCLES, 2, clocks for which we_ is held low per write (≥1).

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  producer has a digit on in_digit
- in_digit  in  4  one-digit ten's-complement BCD value
- in_ready  out  1  block can accept a digit this clock
- addr  out  16  RAM address
- data  out  8  RAM write data {a1,a0}
- we_  out  1  RAM write strobe, active-low
- wrap  out  1  one-clock pulse when the write at END_ADDR completes
- err  out  1  one-clock pulse when an invalid digit (>9) is accepted
- count  out  16  number of successful writes since reset, saturating at 16'hFFFF

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - addr=BASE_ADDR, data=8'h00, we_=1, in_ready=0, wrap=0, err=0, count=0
  - state=IDLE; in_ready rises on the first clock edge after reset deasserts
  - Reset during STROBE must force we_=1 without waiting for a clock edge. The aborted write is not counted and addr is not advanced.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - in_ready=1, we_=1
  - Acceptance occurs on an edge where in_valid=1 and in_ready=1.
  - Accepted digit ≤9: data <= sign-extended byte, next state SETUP, in_ready falls.
  - Accepted digit >9: nothing is written, err=1 for exactly one clock, addr and count unchanged, stays in IDLE.
- SETUP: addr and data stable, we_=1, lasts one clock, then STROBE.
- STROBE: we_=0 for exactly WE_CYCLES clocks, addr and data stable, then HOLD.
- HOLD:
  - we_=1, addr and data stable for one clock
  - On the exit edge: count increments (saturating); addr <= addr+1, or BASE_ADDR if addr==END_ADDR. In the wrap case, wrap=1 for that one clock.
  - Next state IDLE.
- Throughput: accept-to-accept spacing is WE_CYCLES+3 clocks (5 with default).
- data changes only on the acceptance edge. addr changes only on the HOLD exit edge. Neither changes while we_=0.
- Sign extension, for d ≤ 9: a1 = (d<5) ? 4'd0 : 4'd9; a0 = d.
- in_valid is ignored outside IDLE; the producer holds its digit until in_ready is seen.

Decomposition:
- Package bcd_pkg holds:
  - the FSM state typedef: IDLE, SETUP, STROBE, HOLD
  - constants DIGIT_POS_EXT=4'd0, DIGIT_NEG_EXT=4'd9, DIGIT_MAX=4'd9
- One combinational sub-module, bcd_sign_extend: 4-bit digit in; 8-bit packed byte and a valid flag out. Reusable by future reader-side checkers.
- The WE_CYCLES strobe counter lives in the top module.

Test Plan:
- Reset then single digit 3 -> addr=0000, data=8'h03, we_ low for exactly 2 clocks, count=1, addr=0001 afterward.
- Digit 7 -> data=8'h97. Digit 5 -> data=8'h95. Digit 4 -> data=8'h04. Digit 0 -> data=8'h00.
- 32 back-to-back digits with in_valid held high -> writes to 0000..001F, wrap pulses once on the 32nd write, 33rd write goes to 0000. Acceptance spacing must be exactly 5 clocks.
- Digit 4'hC -> err pulses for one clock, we_ never falls, addr and count unchanged. A following digit 2 writes 8'h02 at the unchanged address.
- Reset asserted mid-STROBE -> we_=1 in the same time step before the next edge, addr=0000, count=0, in_ready=0 until the first edge after release.
- WE_CYCLES=1 instance -> we_ low for exactly 1 clock, accept spacing 4 clocks, byte values identical to the default instance.
